// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Holds the fetch PC, reads a synchronous
// instruction ROM with a one-cycle read latency, and buffers returned words
// in a small in-order queue. The queue head is presented to decode as
// {inst, pc, pc+4} over a valid/ready handshake. A redirect from execute
// reloads the fetch PC and squashes everything in flight.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset (word aligned)
//   Q_DEPTH   instruction queue entries (power of two, >= 2)
//   IROM_AW   IROM word-address width; irom_addr = fpc[IROM_AW+1:2]
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           synchronous reset, active low
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     new fetch PC, bits [1:0] are ignored
//   irom_req        IROM read enable this cycle
//   irom_addr       IROM word address
//   irom_rdata      IROM data, valid the cycle after irom_req
//   id_valid        queue head valid to decode
//   id_ready        decode accepts the head this cycle
//   id_inst         head instruction, nop (0x00000013) when id_valid=0
//   id_pc           head PC, 0 when id_valid=0
//   id_pc4          id_pc + 4 (mod 2^32), 0 when id_valid=0
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          Q_DEPTH  = 2,
  parameter int          IROM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               irom_req,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
);

  localparam int          PW  = $clog2(Q_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Fetch PC and the single outstanding request.
  logic [31:0] fpc_reg;
  logic [31:0] req_pc_reg;
  logic        inflight_reg;
  logic        kill_reg;

  // Circular instruction queue. Entries are plain registers so the head can
  // be presented to decode in the same cycle it becomes valid.
  logic [31:0]   q_inst_reg [Q_DEPTH];
  logic [31:0]   q_pc_reg   [Q_DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          head_valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit_used;

  // Only the word-aligned part of a redirect target is meaningful.
  logic          redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // -------------------------------------------------------------------------
  // Next-state and handshake logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    head_valid  = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    issue       = 1'b0;
    credit_used = '0;

    case (state_reg)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase

    // Outputs are forced idle while reset is asserted, whatever the state.
    head_valid = rst_n && (count_reg != '0);
    pop        = head_valid && id_ready;

    // Slots already committed: queued words plus the word returning now,
    // minus the one decode takes this cycle. A new request is only made
    // when its response is guaranteed a free slot next cycle.
    credit_used = {1'b0, count_reg} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);

    issue = rst_n && (state_reg == ST_FETCH) && !redirect_valid &&
            (credit_used < (CW + 1)'(Q_DEPTH));

    // A response returning during a redirect belongs to the old path, as
    // does one returning in the cycle after a redirect.
    push = inflight_reg && !kill_reg && !redirect_valid;
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      fpc_reg      <= RESET_PC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
      kill_reg     <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      kill_reg     <= redirect_valid;

      if (issue) begin
        fpc_reg    <= fpc_reg + 32'd4;
        req_pc_reg <= fpc_reg;
      end

      if (redirect_valid) begin
        // A pop in this cycle still completes at decode; the queue is
        // discarded regardless, so pointers simply restart.
        fpc_reg    <= {redirect_pc[31:2], 2'b00};
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage: each entry captures the returning word when it is the
  // write target. No reset is needed since count_reg gates visibility.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < Q_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          q_inst_reg[gi] <= irom_rdata;
          q_pc_reg[gi]   <= req_pc_reg;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign irom_req  = issue;
  assign irom_addr = fpc_reg[IROM_AW+1:2];

  assign id_valid  = head_valid;
  assign id_inst   = head_valid ? q_inst_reg[rd_ptr_reg] : NOP;
  assign id_pc     = head_valid ? q_pc_reg[rd_ptr_reg] : 32'd0;
  assign id_pc4    = head_valid ? (q_pc_reg[rd_ptr_reg] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Bench for if_fetch_unit. The IROM model returns word address + 0x100. A
// queue holds the PCs decode is expected to see, reloaded whenever the bench
// resets or redirects the unit; every accepted word is checked against it.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          irom_req;
  logic [AW-1:0] irom_addr;
  logic [31:0]   irom_rdata = 32'd0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_inst;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc4;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  logic [31:0] held_pc;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .Q_DEPTH (2),
    .IROM_AW (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .irom_req      (irom_req),
    .irom_addr     (irom_addr),
    .irom_rdata    (irom_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4)
  );

  // Synchronous ROM: data the cycle after the request, garbage otherwise.
  always @(posedge clk) begin
    if (irom_req) irom_rdata <= {18'd0, irom_addr} + 32'h100;
    else          irom_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {18'd0, pc[15:2]} + 32'h100;
  endfunction

  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int target;
    target = pops + n;
    for (int i = 0; i < budget && pops < target; i++) cyc();
    check("pop_timeout", 32'(pops >= target), 32'd1);
  endtask

  // Decode-side monitor: one line per accepted word.
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc", id_pc, mon_e);
        check("inst", id_inst, exp_inst(mon_e));
        check("pc4", id_pc4, mon_e + 32'd4);
        pops++;
        $display("txn pc=%h inst=%h pc4=%h", id_pc, id_inst, id_pc4);
      end
    end else if (rst_n && !id_valid) begin
      check("idle_inst", id_inst, 32'h0000_0013);
      check("idle_pc", id_pc, 32'd0);
      check("idle_pc4", id_pc4, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst_n    = 1'b0;
    id_ready = 1'b1;
    load_stream(32'h0);
    cyc();
    cyc();
    @(negedge clk);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_req", {31'd0, irom_req}, 32'd0);
    check("rst_inst", id_inst, 32'h0000_0013);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc4, 32'd0);

    // Release: BOOT cycle, first request next, id_valid in cycle 3.
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lat_valid", {31'd0, id_valid}, 32'(c == 3));
      check("lat_req", {31'd0, irom_req}, 32'(c >= 1));
      if (c == 1) check("lat_addr", {18'd0, irom_addr}, 32'd0);
      cyc();
    end
    wait_pops(6, 50);

    // Decode stall: head frozen, no requests once the queue is committed.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held_pc = id_pc;
      else check("stall_hold", id_pc, held_pc);
      check("stall_req", {31'd0, irom_req}, 32'd0);
      check("stall_valid", {31'd0, id_valid}, 32'd1);
      cyc();
    end
    id_ready = 1'b1;
    wait_pops(6, 50);

    // Redirect with a word queued and one returning: both dropped.
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    check("redir_req", {31'd0, irom_req}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    load_stream(32'h0000_0040);
    @(negedge clk);
    check("redir1_valid", {31'd0, id_valid}, 32'd0);
    check("redir1_req", {31'd0, irom_req}, 32'd1);
    check("redir1_addr", {18'd0, irom_addr}, 32'h10);
    cyc();
    @(negedge clk);
    check("redir2_valid", {31'd0, id_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("redir3_valid", {31'd0, id_valid}, 32'd1);
    check("redir3_pc", id_pc, 32'h0000_0040);
    cyc();
    id_ready = 1'b1;
    wait_pops(4, 40);

    // Misaligned redirect with a pop in the same cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    @(negedge clk);
    check("rdpop_valid", {31'd0, id_valid}, 32'd1);
    cyc();
    redirect_valid = 1'b0;
    load_stream(32'h0000_0040);
    wait_pops(4, 40);

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    cyc();
    redirect_pc    = 32'h0000_0500;
    load_stream(32'h0000_0500);
    cyc();
    redirect_valid = 1'b0;
    wait_pops(4, 40);

    // Reset for one cycle mid-stream.
    rst_n = 1'b0;
    load_stream(32'h0);
    @(negedge clk);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_req", {31'd0, irom_req}, 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_valid", {31'd0, id_valid}, 32'd0);
    check("boot_req", {31'd0, irom_req}, 32'd0);
    cyc();
    @(negedge clk);
    check("restart_req", {31'd0, irom_req}, 32'd1);
    check("restart_addr", {18'd0, irom_addr}, 32'd0);
    cyc();
    wait_pops(4, 40);

    // Redirect during reset: reset wins.
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0800;
    load_stream(32'h0);
    cyc();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    wait_pops(3, 40);

    // PC wrap at 2^32.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    load_stream(32'hFFFF_FFF8);
    wait_pops(4, 40);

    // Random decode backpressure.
    for (int i = 0; i < 60; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    id_ready = 1'b1;
    wait_pops(3, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
